tutor_answer_serializer: RTL and testbench

Downstream stage of the combinational smart-math-tutor answer generator. On a `start` pulse it captures the 32-bit answer mask (bit *n* set means *n* is a valid answer). It then emits the index of each set bit, in ascending order, over a valid/ready handshake. At the end it pulses `done` and reports how many answers were emitted. It feeds the display/quiz-presentation logic one number at a time.

---
 rtl/tutor_answer_serializer_pkg.sv | 16 +
 rtl/tutor_answer_serializer_if.sv | 27 ++
 rtl/tutor_lsb_encoder.sv | 23 ++
 rtl/tutor_answer_serializer.sv | 104 ++++++++++
 tb/tb_tutor_answer_serializer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/tutor_answer_serializer_pkg.sv
// rtl/tutor_answer_serializer_pkg.sv - shared types and defaults for the answer serializer
package tutor_pkg;

    localparam int W     = 32;
    localparam int IW    = 5;
    localparam int MAX_Q = 32;

    typedef logic [W-1:0] ans_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/tutor_answer_serializer_if.sv
// rtl/tutor_answer_serializer_if.sv - run request, index stream and status bundle
interface tutor_answer_serializer_if #(
    parameter int W  = tutor_pkg::W,
    parameter int IW = tutor_pkg::IW
) ();

    logic          start;
    logic [W-1:0]  mask_in;
    logic          idx_ready;
    logic          idx_valid;
    logic [IW-1:0] idx;
    logic          busy;
    logic          done;
    logic [IW:0]   count;

    // master: generator/consumer side, slave: the serializer
    modport master (
        output start, mask_in, idx_ready,
        input  idx_valid, idx, busy, done, count
    );

    modport slave (
        input  start, mask_in, idx_ready,
        output idx_valid, idx, busy, done, count
    );

endinterface

// File: rtl/tutor_lsb_encoder.sv
// rtl/tutor_lsb_encoder.sv - combinational lowest-set-bit index encoder
module tutor_lsb_encoder #(
    parameter int W  = tutor_pkg::W,
    parameter int IW = tutor_pkg::IW
) (
    input  logic [W-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // scan from the top so the lowest set bit wins; zero input yields index 0
    always_comb begin
        o_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IW'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/tutor_answer_serializer.sv
// rtl/tutor_answer_serializer.sv - emits set-bit indices of an answer mask one per handshake
module tutor_answer_serializer
    import tutor_pkg::*;
#(
    parameter int W     = tutor_pkg::W,
    parameter int IW    = tutor_pkg::IW,
    parameter int MAX_Q = tutor_pkg::MAX_Q
) (
    input logic clk,
    input logic rst_n,
    tutor_answer_serializer_if.slave bus
);

    localparam int          CNT_W   = IW + 1;
    localparam logic [IW:0] MAX_Q_C = CNT_W'(MAX_Q);

    state_t        r_state;
    state_t        w_state_next;
    logic [W-1:0]  r_pend;
    logic [IW:0]   r_count;

    logic [IW-1:0] w_lsb;
    logic          w_any;
    logic          w_valid;
    logic          w_fire;
    logic [W-1:0]  w_pend_clr;
    logic [IW:0]   w_count_inc;
    logic          w_last;

    tutor_lsb_encoder #(
        .W  (W),
        .IW (IW)
    ) u_enc (
        .i_vec (r_pend),
        .o_idx (w_lsb),
        .o_any (w_any)
    );

    // outputs depend only on registered state, so start/mask_in cannot disturb a run
    assign w_valid     = (r_state == ST_EMIT) && w_any && (r_count < MAX_Q_C);
    assign w_fire      = w_valid && bus.idx_ready;
    // x & (x-1) drops the lowest set bit, which is exactly the index on offer
    assign w_pend_clr  = r_pend & (r_pend - W'(1));
    assign w_count_inc = r_count + CNT_W'(1);
    // the accepted index is the final one: leave EMIT now so done lands right after it
    assign w_last      = (w_pend_clr == '0) || (w_count_inc >= MAX_Q_C);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (!w_valid) begin
                    w_state_next = ST_FIN;
                end else if (w_fire && w_last) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // pending mask and accepted-answer counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_count <= '0;
        end else if (r_state == ST_IDLE) begin
            if (bus.start) begin
                r_pend  <= bus.mask_in;
                r_count <= '0;
            end
        end else if (w_fire) begin
            r_pend  <= w_pend_clr;
            r_count <= w_count_inc;
        end
    end

    assign bus.idx_valid = w_valid;
    assign bus.idx       = w_valid ? w_lsb : '0;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_FIN);
    assign bus.count     = r_count;

endmodule

// File: tb/tb_tutor_answer_serializer.sv
// tb/tb_tutor_answer_serializer.sv - directed table and sequence bench for the answer serializer
module tb_tutor_answer_serializer;
    import tutor_pkg::*;

    logic clk;
    logic rst_n;

    tutor_answer_serializer_if #(.W(32), .IW(5)) b1 ();
    tutor_answer_serializer_if #(.W(32), .IW(5)) b2 ();

    tutor_answer_serializer #(.W(32), .IW(5), .MAX_Q(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    tutor_answer_serializer #(.W(32), .IW(5), .MAX_Q(2)) dut_lim (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        ans_mask_t        mask;
        int               n;
        logic [3:0][4:0]  exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 32'(b1.idx_valid), 32'd0);
        chk({tag, " idx"},   32'(b1.idx),       32'd0);
        chk({tag, " busy"},  32'(b1.busy),      32'd0);
        chk({tag, " done"},  32'(b1.done),      32'd0);
    endtask

    task automatic run_full(input string tag, input logic [31:0] m, input int n,
                            input logic [3:0][4:0] e);
        b1.mask_in   = m;
        b1.start     = 1'b1;
        b1.idx_ready = 1'b1;
        step();
        b1.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s valid%0d", tag, i), 32'(b1.idx_valid), 32'd1);
            chk($sformatf("%s idx%0d", tag, i),   32'(b1.idx),       32'(e[i]));
            chk($sformatf("%s busy%0d", tag, i),  32'(b1.busy),      32'd1);
            step();
        end
        if (n == 0) begin
            chk({tag, " empty valid"}, 32'(b1.idx_valid), 32'd0);
            chk({tag, " empty done"},  32'(b1.done),      32'd0);
            chk({tag, " empty busy"},  32'(b1.busy),      32'd1);
            step();
        end
        chk({tag, " done"},  32'(b1.done),      32'd1);
        chk({tag, " count"}, 32'(b1.count),     32'(n));
        chk({tag, " fin valid"}, 32'(b1.idx_valid), 32'd0);
        step();
        chk({tag, " busy off"},  32'(b1.busy),  32'd0);
        chk({tag, " done off"},  32'(b1.done),  32'd0);
        chk({tag, " count hold"}, 32'(b1.count), 32'(n));
    endtask

    initial begin
        vecs[0] = '{mask: 32'h0000_0015, n: 3, exp: {5'd0, 5'd4, 5'd2, 5'd0}};
        vecs[1] = '{mask: 32'h0000_0000, n: 0, exp: {5'd0, 5'd0, 5'd0, 5'd0}};
        vecs[2] = '{mask: 32'h8000_0001, n: 2, exp: {5'd0, 5'd0, 5'd31, 5'd0}};
        vecs[3] = '{mask: 32'h0000_0100, n: 1, exp: {5'd0, 5'd0, 5'd0, 5'd8}};
        vecs[4] = '{mask: 32'hC000_0900, n: 4, exp: {5'd31, 5'd30, 5'd11, 5'd8}};

        rst_n        = 1'b0;
        b1.start     = 1'b0;
        b1.mask_in   = '0;
        b1.idx_ready = 1'b0;
        b2.start     = 1'b0;
        b2.mask_in   = '0;
        b2.idx_ready = 1'b0;
        step();
        step();
        chk_idle("reset");
        chk("reset count", 32'(b1.count), 32'd0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            run_full($sformatf("vec%0d", v), vecs[v].mask, vecs[v].n, vecs[v].exp);
            step();
        end

        // backpressure: idx 0 must stay put while the consumer stalls
        b1.mask_in   = 32'h8000_0001;
        b1.start     = 1'b1;
        b1.idx_ready = 1'b0;
        step();
        b1.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) b1.idx_ready = 1'b1;
            chk($sformatf("bp hold valid%0d", i), 32'(b1.idx_valid), 32'd1);
            chk($sformatf("bp hold idx%0d", i),   32'(b1.idx),       32'd0);
            step();
        end
        chk("bp idx31 valid", 32'(b1.idx_valid), 32'd1);
        chk("bp idx31",       32'(b1.idx),       32'd31);
        step();
        chk("bp done",  32'(b1.done),  32'd1);
        chk("bp count", 32'(b1.count), 32'd2);
        step();
        chk("bp busy off", 32'(b1.busy), 32'd0);
        step();

        // limit: MAX_Q=2 instance stops after two answers
        b2.mask_in   = 32'hFFFF_FFFF;
        b2.start     = 1'b1;
        b2.idx_ready = 1'b1;
        step();
        b2.start = 1'b0;
        chk("lim idx0 valid", 32'(b2.idx_valid), 32'd1);
        chk("lim idx0",       32'(b2.idx),       32'd0);
        step();
        chk("lim idx1 valid", 32'(b2.idx_valid), 32'd1);
        chk("lim idx1",       32'(b2.idx),       32'd1);
        step();
        chk("lim done",  32'(b2.done),      32'd1);
        chk("lim valid", 32'(b2.idx_valid), 32'd0);
        chk("lim count", 32'(b2.count),     32'd2);
        step();
        chk("lim busy off", 32'(b2.busy), 32'd0);
        step();

        // start while busy is ignored
        b1.mask_in   = 32'h0000_0015;
        b1.start     = 1'b1;
        b1.idx_ready = 1'b1;
        step();
        chk("sb idx0", 32'(b1.idx), 32'd0);
        b1.mask_in = 32'h0000_0003;
        step();
        b1.start = 1'b0;
        chk("sb idx1", 32'(b1.idx), 32'd2);
        step();
        chk("sb idx2", 32'(b1.idx), 32'd4);
        step();
        chk("sb done",  32'(b1.done),  32'd1);
        chk("sb count", 32'(b1.count), 32'd3);
        step();
        chk("sb busy off", 32'(b1.busy), 32'd0);
        run_full("sb fresh", 32'h0000_0003, 2, {5'd0, 5'd0, 5'd1, 5'd0});
        step();

        // reset mid-run after the second index
        b1.mask_in   = 32'h0000_0015;
        b1.start     = 1'b1;
        b1.idx_ready = 1'b1;
        step();
        b1.start = 1'b0;
        chk("rm idx0", 32'(b1.idx), 32'd0);
        step();
        chk("rm idx1", 32'(b1.idx), 32'd2);
        step();
        rst_n = 1'b0;
        step();
        chk_idle("rm reset");
        chk("rm count", 32'(b1.count), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rm no done%0d", i), 32'(b1.done), 32'd0);
        end
        run_full("rm basic", 32'h0000_0015, 3, {5'd0, 5'd4, 5'd2, 5'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
